// File: rtl/hdmi_text_controller_if.sv
// AXI4-Lite bus bundle for the text-mode display controller.
// The master modport is the bus initiator (MicroBlaze interconnect or bench).
// The slave modport is the controller itself.
interface hdmi_text_controller_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   axi_awaddr;
    logic [2:0]          axi_awprot;
    logic                axi_awvalid;
    logic                axi_awready;
    logic [DATA_W-1:0]   axi_wdata;
    logic [DATA_W/8-1:0] axi_wstrb;
    logic                axi_wvalid;
    logic                axi_wready;
    logic [1:0]          axi_bresp;
    logic                axi_bvalid;
    logic                axi_bready;
    logic [ADDR_W-1:0]   axi_araddr;
    logic [2:0]          axi_arprot;
    logic                axi_arvalid;
    logic                axi_arready;
    logic [DATA_W-1:0]   axi_rdata;
    logic [1:0]          axi_rresp;
    logic                axi_rvalid;
    logic                axi_rready;

    modport master (
        output axi_awaddr, axi_awprot, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid,
        output axi_bready, axi_araddr, axi_arprot, axi_arvalid, axi_rready,
        input  axi_awready, axi_wready, axi_bresp, axi_bvalid,
        input  axi_arready, axi_rdata, axi_rresp, axi_rvalid
    );

    modport slave (
        input  axi_awaddr, axi_awprot, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid,
        input  axi_bready, axi_araddr, axi_arprot, axi_arvalid, axi_rready,
        output axi_awready, axi_wready, axi_bresp, axi_bvalid,
        output axi_arready, axi_rdata, axi_rresp, axi_rvalid
    );
endinterface

// File: rtl/hdmi_text_controller.sv
// 80x30 text-mode display controller with an AXI4-Lite register window.
// 600 VRAM words (4 characters each) plus one colour CTRL word at index 600.
// Generates 640x480@60 timing from the 100 MHz bus clock (pixel enable every
// 4th cycle) and renders glyphs from a compact built-in font ROM.
// Optional build macro HDMI_TEXT_INVERT_EN: character bit 7 inverts the glyph.
module hdmi_text_controller #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 16
) (
    input  logic                   axi_aclk,
    input  logic                   axi_aresetn,
    hdmi_text_controller_if.slave  axi,
    output logic [3:0]             red,
    output logic [3:0]             green,
    output logic [3:0]             blue,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   vde
);
    localparam int VRAM_WORDS = 600;
    localparam logic [9:0] CTRL_IDX = 10'd600;

    // Handshake semantics: a transfer happens on the rising edge where valid
    // and ready are both high. The master holds valid (and its payload) until
    // that edge. awready/wready and arready are single-cycle pulses raised one
    // cycle after the request is seen; bvalid/rvalid rise the cycle after the
    // transfer and hold until the master's bready/rready is sampled high. No
    // new write (read) is accepted while its response is still pending.

    logic [C_AXI_DATA_WIDTH-1:0] vram_q [0:VRAM_WORDS-1];
    logic [C_AXI_DATA_WIDTH-1:0] ctrl_q;

    logic                        awready_q, awready_d;
    logic                        bvalid_q, bvalid_d;
    logic                        arready_q, arready_d;
    logic                        rvalid_q, rvalid_d;
    logic [C_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                        wr_en, rd_en;
    logic [C_AXI_ADDR_WIDTH-1:0] aw_addr, ar_addr;
    logic [9:0]                  wr_idx, rd_idx;
    logic [C_AXI_DATA_WIDTH-1:0] rd_word;

    logic [1:0]  div_q;
    logic        pix_en;
    logic [9:0]  drawX_q, drawX_d, drawY_q, drawY_d;
    logic        clk_25MHz;
    logic [9:0]  drawX, drawY;

    logic [11:0] char_idx;
    logic [9:0]  disp_idx;
    logic [31:0] disp_word;
    logic [7:0]  char_byte;
    logic [7:0]  font_row;
    logic        glyph_px, px_on;
    logic        unused_bits;

    // Compact built-in font: 'A' follows the usual 8x16 VGA glyph, other
    // printable codes render as a hollow box, control codes and space blank.
    function automatic logic [7:0] font_rom(input logic [10:0] addr);
        logic [6:0] code;
        logic [3:0] row;
        logic [7:0] bits;
        code = addr[10:4];
        row  = addr[3:0];
        bits = 8'h00;
        if (code == 7'h41) begin
            case (row)
                4'd2:    bits = 8'h10;
                4'd3:    bits = 8'h38;
                4'd4:    bits = 8'h6C;
                4'd5,
                4'd6:    bits = 8'hC6;
                4'd7:    bits = 8'hFE;
                4'd8,
                4'd9,
                4'd10,
                4'd11:   bits = 8'hC6;
                default: bits = 8'h00;
            endcase
        end else if (code > 7'h20 && code < 7'h7F) begin
            if (row == 4'd2 || row == 4'd13) begin
                bits = 8'h7E;
            end else if (row > 4'd2 && row < 4'd13) begin
                bits = 8'h42;
            end
        end
        return bits;
    endfunction

    assign aw_addr = axi.axi_awaddr;
    assign ar_addr = axi.axi_araddr;
    assign wr_idx  = aw_addr[11:2];
    assign rd_idx  = ar_addr[11:2];

    // Handshake next-state: request detection, transfer strobes, response hold.
    always_comb begin
        awready_d = axi.axi_awvalid && axi.axi_wvalid && !bvalid_q && !awready_q;
        wr_en     = awready_q && axi.axi_awvalid && axi.axi_wvalid;
        bvalid_d  = bvalid_q;
        if (wr_en) begin
            bvalid_d = 1'b1;
        end else if (bvalid_q && axi.axi_bready) begin
            bvalid_d = 1'b0;
        end
        arready_d = axi.axi_arvalid && !rvalid_q && !arready_q;
        rd_en     = arready_q && axi.axi_arvalid;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        if (rd_en) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_word;
        end else if (rvalid_q && axi.axi_rready) begin
            rvalid_d = 1'b0;
        end
    end

    // Read decode: VRAM, CTRL, or zero for the unmapped tail of the window.
    always_comb begin
        rd_word = '0;
        if (rd_idx < 10'(VRAM_WORDS)) begin
            rd_word = vram_q[rd_idx];
        end else if (rd_idx == CTRL_IDX) begin
            rd_word = ctrl_q;
        end
    end

    // Handshake registers; reset aborts any transaction in flight.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    // Register file: byte-strobed writes into VRAM or CTRL on the transfer edge.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            for (int i = 0; i < VRAM_WORDS; i++) begin
                vram_q[i] <= '0;
            end
            ctrl_q <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < C_AXI_DATA_WIDTH / 8; b++) begin
                if (axi.axi_wstrb[b]) begin
                    if (wr_idx < 10'(VRAM_WORDS)) begin
                        vram_q[wr_idx][8*b +: 8] <= axi.axi_wdata[8*b +: 8];
                    end else if (wr_idx == CTRL_IDX) begin
                        ctrl_q[8*b +: 8] <= axi.axi_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    assign axi.axi_awready = awready_q;
    assign axi.axi_wready  = awready_q;
    assign axi.axi_bvalid  = bvalid_q;
    assign axi.axi_bresp   = 2'b00;
    assign axi.axi_arready = arready_q;
    assign axi.axi_rvalid  = rvalid_q;
    assign axi.axi_rdata   = rdata_q;
    assign axi.axi_rresp   = 2'b00;

    assign pix_en    = (div_q == 2'd3);
    assign clk_25MHz = div_q[1];
    assign drawX     = drawX_q;
    assign drawY     = drawY_q;

    // Raster counters: 800 pixels per line, 525 lines per frame.
    always_comb begin
        drawX_d = drawX_q;
        drawY_d = drawY_q;
        if (pix_en) begin
            if (drawX_q == 10'd799) begin
                drawX_d = 10'd0;
                drawY_d = (drawY_q == 10'd524) ? 10'd0 : drawY_q + 10'd1;
            end else begin
                drawX_d = drawX_q + 10'd1;
            end
        end
    end

    // Clock divider and raster position registers.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            div_q   <= 2'd0;
            drawX_q <= 10'd0;
            drawY_q <= 10'd0;
        end else begin
            div_q   <= div_q + 2'd1;
            drawX_q <= drawX_d;
            drawY_q <= drawY_d;
        end
    end

    assign hsync = !(drawX_q >= 10'd656 && drawX_q <= 10'd751);
    assign vsync = !(drawY_q >= 10'd490 && drawY_q <= 10'd491);
    assign vde   = (drawX_q < 10'd640) && (drawY_q < 10'd480);

    // Glyph lookup and colour selection for the current raster position.
    always_comb begin
        char_idx  = ({6'd0, drawY_q[9:4]} * 12'd80) + {5'd0, drawX_q[9:3]};
        disp_idx  = char_idx[11:2];
        disp_word = (disp_idx < 10'(VRAM_WORDS)) ? vram_q[disp_idx] : 32'd0;
        case (char_idx[1:0])
            2'd0:    char_byte = disp_word[7:0];
            2'd1:    char_byte = disp_word[15:8];
            2'd2:    char_byte = disp_word[23:16];
            default: char_byte = disp_word[31:24];
        endcase
        font_row = font_rom({char_byte[6:0], drawY_q[3:0]});
        glyph_px = font_row[3'd7 - drawX_q[2:0]];
`ifdef HDMI_TEXT_INVERT_EN
        px_on = glyph_px ^ char_byte[7];
`else
        px_on = glyph_px;
`endif
        red   = 4'd0;
        green = 4'd0;
        blue  = 4'd0;
        if (vde) begin
            if (px_on) begin
                red   = ctrl_q[24:21];
                green = ctrl_q[20:17];
                blue  = ctrl_q[16:13];
            end else begin
                red   = ctrl_q[12:9];
                green = ctrl_q[8:5];
                blue  = ctrl_q[4:1];
            end
        end
    end

    // Bits that are deliberately not consumed by the logic above.
    assign unused_bits = &{1'b0, axi.axi_awprot, axi.axi_arprot, aw_addr[1:0],
                           aw_addr[C_AXI_ADDR_WIDTH-1:12], ar_addr[1:0],
                           ar_addr[C_AXI_ADDR_WIDTH-1:12], clk_25MHz, char_byte[7]};
endmodule

// File: tb/tb_hdmi_text_controller.sv
// Directed bench for hdmi_text_controller: reset state, AXI register access,
// raster timing and glyph rendering, with a read-data scoreboard queue.
`timescale 1ns/1ps
module tb_hdmi_text_controller;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hdmi_text_controller_if #(.ADDR_W(16), .DATA_W(32)) axi_if ();
    logic [3:0] red, green, blue;
    logic       hsync, vsync, vde;

    hdmi_text_controller #(.C_AXI_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(16)) dut (
        .axi_aclk   (clk),
        .axi_aresetn(rst_n),
        .axi        (axi_if),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .hsync      (hsync),
        .vsync      (vsync),
        .vde        (vde)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  a_glyph [16];

    localparam logic [31:0] CTRL_A = 32'h001F6000;
    localparam logic [31:0] CTRL_B = 32'h001F74A6;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [11:0] exp_pix(input logic [7:0] chr, input int x, input int row,
                                            input logic [31:0] ctrl);
        logic [7:0] g;
        logic       on;
        g  = (chr[6:0] == 7'h41) ? a_glyph[row] : 8'h00;
        on = g[7 - (x % 8)];
`ifdef HDMI_TEXT_INVERT_EN
        on = on ^ chr[7];
`endif
        return on ? ctrl[24:13] : ctrl[12:1];
    endfunction

    task automatic axi_write(input logic [15:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int hold);
        int n;
        @(negedge clk);
        axi_if.axi_awaddr  = addr;
        axi_if.axi_wdata   = data;
        axi_if.axi_wstrb   = strb;
        axi_if.axi_awvalid = 1'b1;
        axi_if.axi_wvalid  = 1'b1;
        axi_if.axi_bready  = 1'b0;
        n = 0;
        while (!(axi_if.axi_awready && axi_if.axi_wready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wr_handshake", {31'd0, axi_if.axi_awready && axi_if.axi_wready}, 32'd1);
        @(negedge clk);
        axi_if.axi_awvalid = 1'b0;
        axi_if.axi_wvalid  = 1'b0;
        check("awready_pulse", {31'd0, axi_if.axi_awready}, 32'd0);
        check("bvalid_rise", {31'd0, axi_if.axi_bvalid}, 32'd1);
        check("bresp", {30'd0, axi_if.axi_bresp}, 32'd0);
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            check("bvalid_hold", {31'd0, axi_if.axi_bvalid}, 32'd1);
        end
        axi_if.axi_bready = 1'b1;
        @(negedge clk);
        axi_if.axi_bready = 1'b0;
        check("bvalid_fall", {31'd0, axi_if.axi_bvalid}, 32'd0);
    endtask

    task automatic axi_read(input logic [15:0] addr, input logic [31:0] expv);
        int          n;
        logic [31:0] want;
        exp_q.push_back(expv);
        @(negedge clk);
        axi_if.axi_araddr  = addr;
        axi_if.axi_arvalid = 1'b1;
        axi_if.axi_rready  = 1'b0;
        n = 0;
        while (!axi_if.axi_arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rd_handshake", {31'd0, axi_if.axi_arready}, 32'd1);
        check("rvalid_early", {31'd0, axi_if.axi_rvalid}, 32'd0);
        @(negedge clk);
        axi_if.axi_arvalid = 1'b0;
        check("rvalid_rise", {31'd0, axi_if.axi_rvalid}, 32'd1);
        check("arready_pulse", {31'd0, axi_if.axi_arready}, 32'd0);
        want = exp_q.pop_front();
        check("rdata", axi_if.axi_rdata, want);
        check("rresp", {30'd0, axi_if.axi_rresp}, 32'd0);
        axi_if.axi_rready = 1'b1;
        @(negedge clk);
        axi_if.axi_rready = 1'b0;
        check("rvalid_fall", {31'd0, axi_if.axi_rvalid}, 32'd0);
        check("rdata_hold", axi_if.axi_rdata, want);
    endtask

    task automatic wait_pos(input int x, input int y, input int budget, input string tag);
        int n;
        n = 0;
        while (!(dut.drawX == 10'(x) && dut.drawY == 10'(y)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, (dut.drawX == 10'(x) && dut.drawY == 10'(y))}, 32'd1);
    endtask

    initial begin
        int   n, t1, t2, hs_cnt, hs_first, hs_last, vs_low;
        logic [9:0] prev_y;
        logic vde639, vde640;

        a_glyph = '{8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
                    8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00};
        axi_if.axi_awaddr  = '0;
        axi_if.axi_awprot  = 3'd0;
        axi_if.axi_awvalid = 1'b0;
        axi_if.axi_wdata   = '0;
        axi_if.axi_wstrb   = 4'h0;
        axi_if.axi_wvalid  = 1'b0;
        axi_if.axi_bready  = 1'b0;
        axi_if.axi_araddr  = '0;
        axi_if.axi_arprot  = 3'd0;
        axi_if.axi_arvalid = 1'b0;
        axi_if.axi_rready  = 1'b0;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready_valid", {27'd0, axi_if.axi_awready, axi_if.axi_wready, axi_if.axi_bvalid,
                                  axi_if.axi_arready, axi_if.axi_rvalid}, 32'd0);
        check("rst_resp", {28'd0, axi_if.axi_bresp, axi_if.axi_rresp}, 32'd0);
        check("rst_rdata", axi_if.axi_rdata, 32'd0);
        check("rst_sync", {30'd0, hsync, vsync}, 32'd3);
        check("rst_pos", {12'd0, dut.drawX, dut.drawY}, 32'd0);
        check("rst_clk25", {31'd0, dut.clk_25MHz}, 32'd0);
        rst_n = 1'b1;

        // Divider and pixel enable
        repeat (2) @(negedge clk);
        check("clk25_high", {31'd0, dut.clk_25MHz}, 32'd1);
        check("drawx_hold", {22'd0, dut.drawX}, 32'd0);
        repeat (2) @(negedge clk);
        check("clk25_low", {31'd0, dut.clk_25MHz}, 32'd0);
        check("drawx_step", {22'd0, dut.drawX}, 32'd1);

        // Colour register and first VRAM word
        axi_write(16'h0960, CTRL_A, 4'hF, 0);
        axi_read(16'h0960, CTRL_A);
        axi_write(16'h0000, 32'h41414141, 4'hF, 0);
        axi_read(16'h0000, 32'h41414141);

        // Line period, hsync window and vde boundary over line 1
        t1 = -1; t2 = -1; hs_cnt = 0; hs_first = -1; hs_last = -1; vs_low = 0;
        vde639 = 1'bx; vde640 = 1'bx;
        prev_y = dut.drawY;
        for (int c = 0; c < 8000 && t2 < 0; c++) begin
            @(negedge clk);
            if (dut.drawY == 10'd1 && prev_y == 10'd0) t1 = c;
            if (dut.drawY == 10'd2 && prev_y == 10'd1) t2 = c;
            if (dut.drawY == 10'd1) begin
                if (!hsync) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = int'(dut.drawX);
                    hs_last = int'(dut.drawX);
                end
                if (dut.drawX == 10'd639) vde639 = vde;
                if (dut.drawX == 10'd640) vde640 = vde;
            end
            if (!vsync) vs_low++;
            prev_y = dut.drawY;
        end
        check("line_period", 32'(t2 - t1), 32'd3200);
        check("hsync_cycles", 32'(hs_cnt), 32'd384);
        check("hsync_first", 32'(hs_first), 32'd656);
        check("hsync_last", 32'(hs_last), 32'd751);
        check("vsync_idle", 32'(vs_low), 32'd0);
        check("vde_639", {31'd0, vde639}, 32'd1);
        check("vde_640", {31'd0, vde640}, 32'd0);
        check("line2_start", {22'd0, dut.drawX}, 32'd0);

        // Glyph row 2 of 'A' across character 0
        for (int x = 0; x < 8; x++) begin
            check("pix_x_l2", {22'd0, dut.drawX}, 32'(x));
            check("pix_rgb_l2", {20'd0, red, green, blue}, {20'd0, exp_pix(8'h41, x, 2, CTRL_A)});
            repeat (4) @(negedge clk);
        end

        // Non-black background and an inverted character 0
        axi_write(16'h0960, CTRL_B, 4'hF, 0);
        axi_write(16'h0000, 32'h414141C1, 4'hF, 0);
        wait_pos(0, 3, 4000, "reach_line3");
        for (int x = 0; x < 16; x++) begin
            check("pix_x_l3", {22'd0, dut.drawX}, 32'(x));
            check("pix_rgb_l3", {20'd0, red, green, blue},
                  {20'd0, exp_pix((x < 8) ? 8'hC1 : 8'h41, x, 3, CTRL_B)});
            repeat (4) @(negedge clk);
        end
        wait_pos(639, 3, 4000, "reach_x639");
        check("rgb_x639_bg", {20'd0, red, green, blue}, {20'd0, CTRL_B[12:1]});
        check("vde_x639", {31'd0, vde}, 32'd1);
        wait_pos(640, 3, 16, "reach_x640");
        check("rgb_blank", {20'd0, red, green, blue}, 32'd0);
        check("vde_x640", {31'd0, vde}, 32'd0);

        // Fill all VRAM words and read them back
        for (int i = 0; i < 600; i++) axi_write(16'(i * 4), 32'(i), 4'hF, 0);
        for (int i = 0; i < 600; i++) axi_read(16'(i * 4), 32'(i));

        // Byte strobes
        axi_write(16'h0014, 32'h12345678, 4'hF, 0);
        axi_write(16'h0014, 32'h0000AB00, 4'b0010, 0);
        axi_read(16'h0014, 32'h1234AB78);

        // Unmapped words; CTRL must be untouched
        axi_write(16'h0A00, 32'hDEADBEEF, 4'hF, 0);
        axi_read(16'h0A00, 32'd0);
        axi_write(16'h0964, 32'hFFFFFFFF, 4'hF, 2);
        axi_read(16'h0964, 32'd0);
        axi_read(16'h0960, CTRL_B);

        // Pending response blocks a second write
        @(negedge clk);
        axi_if.axi_awaddr  = 16'h0024;
        axi_if.axi_wdata   = 32'h99990000;
        axi_if.axi_wstrb   = 4'hF;
        axi_if.axi_awvalid = 1'b1;
        axi_if.axi_wvalid  = 1'b1;
        n = 0;
        while (!axi_if.axi_awready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("blk_handshake", {31'd0, axi_if.axi_awready}, 32'd1);
        @(negedge clk);
        axi_if.axi_wdata = 32'h11112222;
        for (int k = 0; k < 4; k++) begin
            check("blk_awready", {31'd0, axi_if.axi_awready}, 32'd0);
            check("blk_bvalid", {31'd0, axi_if.axi_bvalid}, 32'd1);
            @(negedge clk);
        end
        axi_if.axi_awvalid = 1'b0;
        axi_if.axi_wvalid  = 1'b0;
        axi_if.axi_bready  = 1'b1;
        @(negedge clk);
        axi_if.axi_bready = 1'b0;
        check("blk_bvalid_fall", {31'd0, axi_if.axi_bvalid}, 32'd0);
        axi_read(16'h0024, 32'h99990000);

        // Simultaneous read and write of the same word returns the old value
        exp_q.push_back(32'd7);
        @(negedge clk);
        axi_if.axi_awaddr  = 16'h001C;
        axi_if.axi_wdata   = 32'hCAFEF00D;
        axi_if.axi_wstrb   = 4'hF;
        axi_if.axi_awvalid = 1'b1;
        axi_if.axi_wvalid  = 1'b1;
        axi_if.axi_araddr  = 16'h001C;
        axi_if.axi_arvalid = 1'b1;
        n = 0;
        while (!axi_if.axi_awready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("sim_both_ready", {30'd0, axi_if.axi_awready, axi_if.axi_arready}, 32'd3);
        @(negedge clk);
        axi_if.axi_awvalid = 1'b0;
        axi_if.axi_wvalid  = 1'b0;
        axi_if.axi_arvalid = 1'b0;
        check("sim_both_valid", {30'd0, axi_if.axi_bvalid, axi_if.axi_rvalid}, 32'd3);
        check("sim_old_rdata", axi_if.axi_rdata, exp_q.pop_front());
        axi_if.axi_bready = 1'b1;
        axi_if.axi_rready = 1'b1;
        @(negedge clk);
        axi_if.axi_bready = 1'b0;
        axi_if.axi_rready = 1'b0;
        axi_read(16'h001C, 32'hCAFEF00D);

        // Reset in the middle of a transaction
        @(negedge clk);
        axi_if.axi_awaddr  = 16'h0030;
        axi_if.axi_wdata   = 32'h55555555;
        axi_if.axi_awvalid = 1'b1;
        axi_if.axi_wvalid  = 1'b1;
        axi_if.axi_araddr  = 16'h0030;
        axi_if.axi_arvalid = 1'b1;
        n = 0;
        while (!axi_if.axi_awready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_ready", {30'd0, axi_if.axi_awready, axi_if.axi_arready}, 32'd3);
        rst_n = 1'b0;
        #1;
        check("mid_abort", {27'd0, axi_if.axi_awready, axi_if.axi_wready, axi_if.axi_bvalid,
                            axi_if.axi_arready, axi_if.axi_rvalid}, 32'd0);
        check("mid_pos", {12'd0, dut.drawX, dut.drawY}, 32'd0);
        axi_if.axi_awvalid = 1'b0;
        axi_if.axi_wvalid  = 1'b0;
        axi_if.axi_arvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        axi_read(16'h0014, 32'd0);
        axi_read(16'h0960, 32'd0);
        axi_read(16'h0030, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/hdmi_text_controller.md
# hdmi_text_controller

AXI4-Lite-mapped 80×30 text-mode display controller. A bus master writes character codes into 600 words of video RAM plus one colour control register. The block generates 640×480@60 Hz VGA timing from the bus clock and renders glyphs from the shared font ROM into 4-bit-per-channel RGB. It sits between the MicroBlaze AXI interconnect and the HDMI/TMDS encoder, which is out of scope.

## Interface
- C_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_AXI_ADDR_WIDTH, 16, AXI byte-address width; only bits [11:2] are decoded.
- axi_aclk  in  1  single clock, 100 MHz.
- axi_aresetn  in  1  reset, asynchronous, active-low.
- axi_awaddr/awprot/awvalid/awready  in/in/in/out  ADDR/3/1/1  write address channel; awprot is ignored.
- axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel.
- axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
- axi_araddr/arprot/arvalid/arready  in/in/in/out  ADDR/3/1/1  read address channel; arprot is ignored.
- axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel.
- red, green, blue  out  4 each  pixel colour.
- hsync, vsync  out  1 each  active-low sync.
- vde  out  1  video data enable (not blanking).
- Internal nets named clk_25MHz, drawX[9:0], drawY[9:0], red, green, blue, hsync, vsync and vde must exist at the top level, for hierarchical probing.

## Operation
- Register map: word index = addr[11:2].
  - Words 0–599: VRAM, 4 characters per word. Byte 0 (bits [7:0]) is the leftmost character.
  - Word 600: CTRL.
  - Words 601–1023: writes are ignored; reads return 0.
- CTRL fields:
  - [24:21] FG_R, [20:17] FG_G, [16:13] FG_B.
  - [12:9] BG_R, [8:5] BG_G, [4:1] BG_B.
  - All 32 bits are stored and read back verbatim.
- Writes honour wstrb per byte. All registers reset to 0.
- Pixel timing:
  - A 2-bit divider on axi_aclk gives clk_25MHz = div[1].
  - The pixel enable is active when div==3.
  - Counters drawX 0–799 and drawY 0–524 advance on each pixel enable. drawY increments when drawX wraps.
- Sync and enable decode:
  - hsync = 0 for drawX 656–751.
  - vsync = 0 for drawY 490–491.
  - vde = (drawX<640)&&(drawY<480).
- Rendering (combinational from drawX/drawY):
  - Character index = (drawY>>4)*80 + (drawX>>3).
  - VRAM word = index>>2; byte = index[1:0].
  - Code = byte[6:0]; inv = byte[7].
  - Font ROM address = {code, drawY[3:0]} (11 bits); pixel = font_data[7-drawX[2:0]].
  - On = pixel XOR inv. RGB = FG when on, BG when off.
  - RGB = 0 when !vde.

## Timing
- Reset values:
  - awready=wready=bvalid=arready=rvalid=0; bresp=rresp=0; rdata=0.
  - div=0, drawX=drawY=0, hsync=vsync=1.
- Write handshake:
  - When awvalid&&wvalid&&!bvalid, awready and wready pulse high together for exactly one cycle and the register updates on that edge.
  - bvalid rises the next cycle and holds until bready is sampled high.
  - A new write is not accepted while bvalid=1.
- Read handshake:
  - When arvalid&&!rvalid, arready pulses for one cycle.
  - rvalid rises the next cycle with rdata registered, and holds until rready.
  - rdata holds its last value after rvalid falls.
- Simultaneous read and write:
  - Both proceed independently.
  - A read of the word written in the same cycle returns the old value.
- Video RAM writes take effect on the displayed pixel one pixel period later at most; no tearing protection.
- Reset mid-transaction: all handshakes abort immediately; valid/ready outputs return to 0.

## Configuration
- HDMI_TEXT_INVERT_EN defined: byte bit 7 inverts the glyph (swaps FG/BG for that cell).
- HDMI_TEXT_INVERT_EN undefined: bit 7 is stored and read back but ignored for rendering.

## Test plan
- Write CTRL (addr 0x960) = 0x001F6000 -> bresp=0; readback = 0x001F6000; FG=(0,F,B), BG=(0,0,0).
- Write word i = i for i=0..599 -> readback of every word equals i, with rvalid exactly one cycle after arready.
- Write 0xAB with wstrb=4'b0010 to word 5, previously 0x12345678 -> readback = 0x1234AB78.
- Write and read addr 0xA00 (word 640) -> write is ignored; read returns 0; handshakes still complete.
- Free-run after reset -> drawX period = 3200 aclk cycles; hsync low for 96 pixels; vsync low for lines 490–491; frame = 525 lines.
- VRAM word 0 = 0x00000041, CTRL as above, 'A' glyph row 0 = 0x00 -> pixel (0,0) is BG black. Set byte bit 7 (with HDMI_TEXT_INVERT_EN) -> pixel is FG (0,F,B).
